// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and the
// bitwise helper functions used by the compression datapath.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // FSM encoding kept as plain constants so older tools can read it.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ROUND  = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;
    localparam state_t ST_OUTPUT = 2'd3;

    localparam int unsigned NUM_ROUNDS = 64;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Upper-case sigma: applied to the working variables a and e.
    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    // Lower-case sigma: used only by the message schedule.
    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message schedule. win[0] is always the word for the
// current round; each advance shifts the window down by one and appends
// the next expanded word, so W16..W63 are produced just in time.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         advance,
    input  logic [511:0] block_in,
    output word_t        w_out
);

    word_t win_q [0:15];
    word_t win_d [0:15];
    word_t w_new;

    // Next window contents: parallel load, shift-and-expand, or hold.
    always_comb begin
        w_new = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = block_in[511 - 32*i -: 32];
            end
        end else if (advance) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_new;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            // One window word register.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    win_q[gi] <= '0;
                end else begin
                    win_q[gi] <= win_d[gi];
                end
            end
        end
    endgenerate

    assign w_out = win_q[0];

endmodule

// File: rtl/sha256_hash_compress.sv
// SHA-256 compression engine: accepts padded 512-bit blocks, runs one
// round per clock, chains the intermediate hash across the blocks of a
// message and presents the final digest on a valid/ready output.
module sha256_hash_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [255:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       first_blk_q, first_blk_d;
    logic       last_q, last_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    word_t work_q [0:7];
    word_t work_d [0:7];
    word_t h_q    [0:7];
    word_t h_d    [0:7];

    word_t w_t;
    word_t t1;
    word_t t2;
    logic  accept;
    logic  sched_adv;

    // in_ready_q is only ever high while sitting in IDLE.
    assign accept = data_in_valid && in_ready_q;

    sha256_msg_schedule u_sched (
        .clk      (clk),
        .nrst     (nrst),
        .load     (accept),
        .advance  (sched_adv),
        .block_in (data_in),
        .w_out    (w_t)
    );

    // Round function terms for the current round (a..h = work[0..7]).
    always_comb begin
        t1 = work_q[7] + bsig1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
             + K[cnt_q] + w_t;
        t2 = bsig0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
    end

    // FSM sequencing, round update, hash accumulation and handshake flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_blk_d = first_blk_q;
        last_d      = last_q;
        sched_adv   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            work_d[i] = work_q[i];
            h_d[i]    = h_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_d = data_in_last;
                    cnt_d  = '0;
                    for (int i = 0; i < 8; i++) begin
                        if (first_blk_q) begin
                            h_d[i]    = IV[i];
                            work_d[i] = IV[i];
                        end else begin
                            work_d[i] = h_q[i];
                        end
                    end
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                sched_adv = 1'b1;
                cnt_d     = cnt_q + 6'd1;
                work_d[0] = t1 + t2;
                work_d[1] = work_q[0];
                work_d[2] = work_q[1];
                work_d[3] = work_q[2];
                work_d[4] = work_q[3] + t1;
                work_d[5] = work_q[4];
                work_d[6] = work_q[5];
                work_d[7] = work_q[6];
                if (cnt_q == 6'(NUM_ROUNDS - 1)) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + work_q[i];
                end
                // A finished message makes the next block start from IV.
                first_blk_d = last_q;
                state_d     = last_q ? ST_OUTPUT : ST_IDLE;
            end
            ST_OUTPUT: begin
                if (data_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUTPUT);
    end

    // Control registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_blk_q <= 1'b1;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_blk_q <= first_blk_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_words
            // Working variable and chaining hash word gi.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    work_q[gi] <= '0;
                    h_q[gi]    <= '0;
                end else begin
                    work_q[gi] <= work_d[gi];
                    h_q[gi]    <= h_d[gi];
                end
            end

            // H only changes in IDLE/UPDATE, so the digest is stable in OUTPUT.
            assign data_out[255 - 32*gi -: 32] = h_q[gi];
        end
    endgenerate

    assign data_in_ready  = in_ready_q;
    assign data_out_valid = out_valid_q;

endmodule
